// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one datapath ALU between two requesters. Incoming requests are
//   granted round-robin. The granted operands and control are registered onto
//   the ALU ports. After ALU_LAT cycles the result and zero flag are captured
//   and returned on a single response channel, tagged with the requester id.
//   Only one operation is in flight at any time.
//
// Parameters
//   WIDTH    operand/result width
//   ALU_LAT  cycles from ALU input update to result sampling (1..15)
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready           requester N handshake (ready is combinational)
//   reqN_a/b/ctrl              requester N operands and alucontrol code
//   rsp_valid/ready            response handshake
//   rsp_id/result/zero         owning requester, captured result and zero flag
//   alu_a/b/ctrl               registered drive to the ALU
//   alu_result/zero            ALU outputs
//   busy                       state is not IDLE
//
// Optional (`define ALU_ARB_STATS_EN)
//   stats_clr                  synchronous clear of both grant counters
//   grant_cnt0/1               16-bit wrapping count of accepted requests
//
// state | meaning
// IDLE  | waiting for a request; alu_* keep their last values
// EXEC  | operands on the ALU, down-counting ALU_LAT cycles
// RESP  | response held until rsp_ready
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

  state_t     state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       grant;
  logic       accept;

  // A lone requester always wins; on a tie the one not served last time wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) & req0_valid & ~grant;
  assign req1_ready = (state == IDLE) & req1_valid &  grant;
  assign accept     = req0_ready | req1_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= grant ? req1_a    : req0_a;
            alu_b      <= grant ? req1_b    : req0_b;
            alu_ctrl   <= grant ? req1_ctrl : req0_ctrl;
            rsp_id     <= grant;
            last_grant <= grant;
            cnt        <= LAT_INIT;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // Terminal count at 1 so the sample edge is exactly ALU_LAT edges
          // after the accepting edge.
          if (cnt == 4'd1) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Clear has priority over a coincident accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (stats_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0]  req0_ctrl = 0, req1_ctrl = 0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_zero;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero, busy;

  logic        rst3_n = 1'b0;
  logic        q0_valid = 0, q1_valid = 0;
  logic        q0_ready, q1_ready;
  logic [31:0] q0_a = 0, q0_b = 0, q1_a = 0, q1_b = 0;
  logic [2:0]  q0_ctrl = 0, q1_ctrl = 0;
  logic        rsp3_valid, rsp3_id, rsp3_zero, alu3_zero, busy3;
  logic [31:0] rsp3_result, alu3_a, alu3_b, alu3_result;
  logic [2:0]  alu3_ctrl;

`ifdef ALU_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] gc0, gc1, gc3_0, gc3_1;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result  = alu_f(alu_a, alu_b, alu_ctrl);
  assign alu_zero    = (alu_result == 32'd0);
  assign alu3_result = alu_f(alu3_a, alu3_b, alu3_ctrl);
  assign alu3_zero   = (alu3_result == 32'd0);

  alu_arbiter #(.WIDTH(32), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt0(gc0), .grant_cnt1(gc1)
`endif
  );

  alu_arbiter #(.WIDTH(32), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .req0_valid(q0_valid), .req0_ready(q0_ready), .req0_a(q0_a), .req0_b(q0_b),
    .req0_ctrl(q0_ctrl),
    .req1_valid(q1_valid), .req1_ready(q1_ready), .req1_a(q1_a), .req1_b(q1_b),
    .req1_ctrl(q1_ctrl),
    .rsp_valid(rsp3_valid), .rsp_ready(1'b1), .rsp_id(rsp3_id),
    .rsp_result(rsp3_result), .rsp_zero(rsp3_zero),
    .alu_a(alu3_a), .alu_b(alu3_b), .alu_ctrl(alu3_ctrl),
    .alu_result(alu3_result), .alu_zero(alu3_zero), .busy(busy3)
`ifdef ALU_ARB_STATS_EN
    , .stats_clr(1'b0), .grant_cnt0(gc3_0), .grant_cnt1(gc3_1)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        z;
  } exp_t;
  exp_t sbq[$];

  // Response scoreboard for the ALU_LAT=1 instance.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        fail_now("sb_unexpected_rsp");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
        chk("sb_rsp_result", rsp_result, e.res);
        chk("sb_rsp_zero", 32'(rsp_zero), 32'(e.z));
      end
    end
  end

  typedef struct {
    logic        who;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic        z;
  } vec_t;
  vec_t tbl[9];

  task automatic drain();
    for (int t = 0; t < 50 && sbq.size() > 0; t++) @(negedge clk);
    if (sbq.size() > 0) begin
      fail_now("drain");
      sbq.delete();
    end
  endtask

  task automatic do_op(input int i);
    bit ok = 0;
    @(posedge clk); #1;
    if (tbl[i].who) begin
      req1_valid = 1; req1_a = tbl[i].a; req1_b = tbl[i].b; req1_ctrl = tbl[i].ctrl;
    end else begin
      req0_valid = 1; req0_a = tbl[i].a; req0_b = tbl[i].b; req0_ctrl = tbl[i].ctrl;
    end
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (tbl[i].who ? req1_ready : req0_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      fail_now("tbl_ready");
      req0_valid = 0; req1_valid = 0;
      return;
    end
    chk("tbl_other_ready", 32'(tbl[i].who ? req0_ready : req1_ready), 32'd0);
    sbq.push_back('{tbl[i].who, tbl[i].res, tbl[i].z});
    @(posedge clk); #1;
    // Scramble requester inputs after accept; the op in flight must not see it.
    req0_valid = 0; req1_valid = 0;
    req0_a = ~req0_a; req0_b = ~req0_b; req1_a = ~req1_a; req1_b = ~req1_b;
    @(negedge clk);
    chk("tbl_alu_a", alu_a, tbl[i].a);
    chk("tbl_alu_b", alu_b, tbl[i].b);
    chk("tbl_alu_ctrl", 32'(alu_ctrl), 32'(tbl[i].ctrl));
    drain();
  endtask

  initial begin
    bit ok;
    bit seen;

    tbl[0] = '{1'b0, 32'h0000000B, 32'h0000000B, 3'b110, 32'h00000000, 1'b1};
    tbl[1] = '{1'b1, 32'h00000005, 32'h00000003, 3'b010, 32'h00000008, 1'b0};
    tbl[2] = '{1'b0, 32'h000000F0, 32'h0000000F, 3'b000, 32'h00000000, 1'b1};
    tbl[3] = '{1'b1, 32'h000000F0, 32'h0000000F, 3'b001, 32'h000000FF, 1'b0};
    tbl[4] = '{1'b0, 32'h00000003, 32'h00000005, 3'b110, 32'hFFFFFFFE, 1'b0};
    tbl[5] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1};
    tbl[6] = '{1'b0, 32'h00000007, 32'h00000009, 3'b111, 32'h00000001, 1'b0};
    tbl[7] = '{1'b1, 32'h80000000, 32'h00000001, 3'b111, 32'h00000001, 1'b0};
    tbl[8] = '{1'b0, 32'h00000001, 32'h00000002, 3'b011, 32'h00000000, 1'b1};

    // Reset state
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", 32'(rsp_zero), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1; rst3_n = 1;

    // Single op, ALU_LAT=1
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 32'hB; req0_b = 32'hB; req0_ctrl = 3'b110;
    @(negedge clk);
    chk("single_ready0", 32'(req0_ready), 1);
    chk("single_rsp_valid_c0", 32'(rsp_valid), 0);
    sbq.push_back('{1'b0, 32'h0, 1'b1});
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    chk("single_ready0_drop", 32'(req0_ready), 0);
    chk("single_rsp_valid_c1", 32'(rsp_valid), 0);
    chk("single_busy", 32'(busy), 1);
    chk("single_alu_a", alu_a, 32'hB);
    chk("single_alu_ctrl", 32'(alu_ctrl), 32'b110);
    @(negedge clk);
    chk("single_rsp_valid_c2", 32'(rsp_valid), 1);
    @(negedge clk);
    chk("single_rsp_valid_c3", 32'(rsp_valid), 0);
    chk("single_busy_done", 32'(busy), 0);
    chk("single_alu_hold", alu_a, 32'hB);
    drain();

    // Reset, then tie + fairness over 6 ops
    @(posedge clk); #1 rst_n = 0;
    #3 rst_n = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 32'hB; req0_b = 32'hA; req0_ctrl = 3'b111;
    req1_valid = 1; req1_a = 32'hA; req1_b = 32'hB; req1_ctrl = 3'b111;
    for (int k = 0; k < 6; k++) begin
      ok = 0;
      for (int t = 0; t < 30; t++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin ok = 1; break; end
      end
      if (!ok) begin fail_now("fair_ready"); break; end
      chk("fair_grant", 32'(req1_ready), 32'(k % 2));
      chk("fair_onehot", 32'(req0_ready & req1_ready), 0);
      sbq.push_back('{(k % 2) == 1, 32'(k % 2), (k % 2) == 0});
      @(posedge clk);
    end
    #1 req0_valid = 0; req1_valid = 0;
    drain();

`ifdef ALU_ARB_STATS_EN
    @(negedge clk);
    chk("stats_fair_cnt0", 32'(gc0), 3);
    chk("stats_fair_cnt1", 32'(gc1), 3);
    @(posedge clk); #1 stats_clr = 1;
    @(posedge clk); #1 stats_clr = 0;
    @(negedge clk);
    chk("stats_clr_cnt0", 32'(gc0), 0);
    chk("stats_clr_cnt1", 32'(gc1), 0);
`endif

    // Table-driven ops; first five are 3 from req0 and 2 from req1
    for (int i = 0; i < 9; i++) begin
      do_op(i);
`ifdef ALU_ARB_STATS_EN
      if (i == 4) begin
        chk("stats_cnt0", 32'(gc0), 3);
        chk("stats_cnt1", 32'(gc1), 2);
      end
`endif
    end

    // Backpressure: rsp_ready low for 10 cycles, both requesters pushing
    @(posedge clk); #1;
    rsp_ready = 0;
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 3'b010;
    req1_valid = 1; req1_a = 32'd1; req1_b = 32'd1; req1_ctrl = 3'b010;
    ok = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("bp_ready");
    // last served was req0 (tbl[8]), so the tie goes to req1
    chk("bp_grant", 32'(req1_ready), 1);
    sbq.push_back('{1'b1, 32'd2, 1'b0});
    ok = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    if (!ok) fail_now("bp_rsp_valid");
    for (int c = 0; c < 10; c++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_result", rsp_result, 32'd2);
      chk("bp_rsp_id", 32'(rsp_id), 1);
      chk("bp_ready0", 32'(req0_ready), 0);
      chk("bp_ready1", 32'(req1_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    rsp_ready = 1;
    drain();

    // ALU_LAT=3 instance: tie after reset, then reset during EXEC
    @(posedge clk); #1;
    q0_valid = 1; q0_a = 32'hB; q0_b = 32'hA; q0_ctrl = 3'b111;
    q1_valid = 1; q1_a = 32'hA; q1_b = 32'hB; q1_ctrl = 3'b111;
    @(negedge clk);
    chk("l3_tie_ready0", 32'(q0_ready), 1);
    chk("l3_tie_ready1", 32'(q1_ready), 0);
    @(posedge clk); #1 q0_valid = 0; q1_valid = 0;
    @(negedge clk);
    chk("l3_busy", 32'(busy3), 1);
    chk("l3_alu_a", alu3_a, 32'hB);
    @(posedge clk); #1 rst3_n = 0;
    #1;
    chk("midrst_busy", 32'(busy3), 0);
    chk("midrst_alu_a", alu3_a, 0);
    chk("midrst_rsp_valid", 32'(rsp3_valid), 0);
    #2 rst3_n = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp3_valid) seen = 1;
    end
    chk("midrst_no_rsp", 32'(seen), 0);

    // Next tie must again go to req0; then measure the 3-cycle latency
    @(posedge clk); #1;
    q0_valid = 1; q1_valid = 1;
    @(negedge clk);
    chk("midrst_tie_ready0", 32'(q0_ready), 1);
    chk("midrst_tie_ready1", 32'(q1_ready), 0);
    @(posedge clk); #1 q0_valid = 0; q1_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("l3_latency", 32'(rsp3_valid), (c == 4) ? 32'd1 : 32'd0);
    end
    chk("l3_rsp_id", 32'(rsp3_id), 0);
    chk("l3_rsp_result", rsp3_result, 0);
    chk("l3_rsp_zero", 32'(rsp3_zero), 1);
    @(negedge clk);
    chk("l3_rsp_drop", 32'(rsp3_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
